// File: rtl/data_memory_pkg.sv
// Shared types for the multi-channel data memory model: channel states, op kinds
// and the wrapped word-address helper used when packing multi-word reads.
package data_memory_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WAIT = 2'd1,
    CH_RESP = 2'd2
  } chan_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Address of word k of a read starting at base, wrapping modulo 2^abits.
  function automatic int unsigned wrap_addr(input int unsigned base,
                                            input int unsigned k,
                                            input int unsigned abits);
    return (base + k) & ((32'd1 << abits) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One request channel: valid/ready handshake, fixed-latency countdown and the
// latched request, with strobes telling the top level when to commit or capture.
module mem_channel_fsm
  import data_memory_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid_i,
  input  logic [ADDR_BITS-1:0] read_addr_i,
  input  logic                 write_valid_i,
  input  logic [ADDR_BITS-1:0] write_addr_i,
  input  logic [DATA_BITS-1:0] write_data_i,
  output logic                 read_ready_o,
  output logic                 write_ready_o,
  output logic                 commit_o,
  output logic                 capture_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [DATA_BITS-1:0] wdata_o
);

  localparam logic [1:0] S_IDLE = CH_IDLE;
  localparam logic [1:0] S_WAIT = CH_WAIT;
  localparam logic [1:0] S_RESP = CH_RESP;
  localparam int CNT_W = $clog2(LATENCY) + 1;

  logic [1:0]           state_q, state_d;
  op_e                  op_q, op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 active_valid;

  assign active_valid = (op_q == OP_READ) ? read_valid_i : write_valid_i;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (read_valid_i) begin
          op_d    = OP_READ;
          addr_d  = read_addr_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end else if (write_valid_i) begin
          op_d    = OP_WRITE;
          addr_d  = write_addr_i;
          wdata_d = write_data_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!active_valid)    state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_RESP;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      S_RESP: begin
        if (!active_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // The edge leaving WAIT for RESP is the one that commits or captures; reset blocks it.
  logic fire;
  assign fire = reset && (state_q == S_WAIT) && active_valid && (cnt_q == '0);

  assign commit_o      = fire && (op_q == OP_WRITE);
  assign capture_o     = fire && (op_q == OP_READ);
  assign addr_o        = addr_q;
  assign wdata_o       = wdata_q;
  assign read_ready_o  = (state_q == S_RESP) && (op_q == OP_READ);
  assign write_ready_o = (state_q == S_RESP) && (op_q == OP_WRITE);

endmodule

// File: rtl/data_memory_model.sv
// Multi-channel fixed-latency data memory with a preload port; owns the array,
// resolves same-edge write priority and packs multi-word read responses.
module data_memory_model
  import data_memory_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int READ_NUM     = 4,
  parameter int LATENCY      = 2
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [NUM_CHANNELS-1:0]                            mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]             mem_read_address,
  output logic [NUM_CHANNELS-1:0]                            mem_read_ready,
  output logic [NUM_CHANNELS-1:0][READ_NUM*DATA_BITS-1:0]    mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                            mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]             mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]             mem_write_data,
  output logic [NUM_CHANNELS-1:0]                            mem_write_ready,
  input  logic                                               load_valid,
  input  logic [ADDR_BITS-1:0]                               load_address,
  input  logic [DATA_BITS-1:0]                               load_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  logic [NUM_CHANNELS-1:0]                         commit, capture;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]          ch_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]          ch_wdata;
  logic [NUM_CHANNELS-1:0][READ_NUM*DATA_BITS-1:0] rdata_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    mem_channel_fsm #(
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .LATENCY  (LATENCY)
    ) u_fsm (
      .clk          (clk),
      .reset        (reset),
      .read_valid_i (mem_read_valid[c]),
      .read_addr_i  (mem_read_address[c]),
      .write_valid_i(mem_write_valid[c]),
      .write_addr_i (mem_write_address[c]),
      .write_data_i (mem_write_data[c]),
      .read_ready_o (mem_read_ready[c]),
      .write_ready_o(mem_write_ready[c]),
      .commit_o     (commit[c]),
      .capture_o    (capture[c]),
      .addr_o       (ch_addr[c]),
      .wdata_o      (ch_wdata[c])
    );
  end

  // Later assignments win: load first, then channels in ascending index order.
  always_ff @(posedge clk) begin
    if (load_valid) mem[load_address] <= load_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (commit[c]) mem[ch_addr[c]] <= ch_wdata[c];
    end
  end

  // Nonblocking array updates make same-edge captures see pre-write contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (capture[c]) begin
          for (int k = 0; k < READ_NUM; k++) begin
            rdata_q[c][k*DATA_BITS +: DATA_BITS] <=
              mem[ADDR_BITS'(wrap_addr(32'(ch_addr[c]), k, ADDR_BITS))];
          end
        end
      end
    end
  end

  assign mem_read_data = rdata_q;

endmodule
